// File: rtl/mskdata_holder_feeder.sv
// Handshake/control stage feeding the masked data holder shift register:
// loads NSTAGES shared words, exposes the full content, and runs refresh rotations.
module mskdata_holder_feeder #(
    parameter int d          = 2,
    parameter int BITS       = 256,
    parameter int RFRSH_RATE = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [d*RFRSH_RATE-1:0]     in_data,
    input  logic                        rnd_valid,
    output logic                        rnd_ready,
    input  logic [(d-1)*RFRSH_RATE-1:0] rnd_in,
    input  logic                        refresh_req,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy_refresh,
    output logic [d*RFRSH_RATE-1:0]     holder_shares,
    output logic [(d-1)*RFRSH_RATE-1:0] holder_rnd,
    output logic [d-1:0]                holder_enable,
    output logic                        holder_fetch
);

    localparam int NSTAGES = BITS / RFRSH_RATE;
    localparam int CW      = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSTAGES - 1);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        FULL    = 2'd1,
        REFRESH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic in_ready_c, rnd_ready_c, out_valid_c, busy_c, enable_c, fetch_c;
    logic live;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_c  = 1'b0;
        rnd_ready_c = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        enable_c    = 1'b0;
        fetch_c     = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready_c = 1'b1;
                fetch_c    = 1'b1;
                enable_c   = in_valid;
                if (in_valid) begin
                    if (cnt_q == LAST) begin
                        state_d = FULL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            FULL: begin
                out_valid_c = 1'b1;
                // Consumption takes priority; a simultaneous refresh request is dropped.
                if (out_ready) begin
                    state_d = LOAD;
                end else if (refresh_req) begin
                    state_d = REFRESH;
                    cnt_d   = '0;
                end
            end
            REFRESH: begin
                busy_c      = 1'b1;
                rnd_ready_c = 1'b1;
                enable_c    = rnd_valid;
                if (rnd_valid) begin
                    if (cnt_q == LAST) begin
                        state_d = FULL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    // Every output is forced low while reset is asserted, including the data wiring.
    assign live         = ~rst;
    assign in_ready     = in_ready_c & live;
    assign rnd_ready    = rnd_ready_c & live;
    assign out_valid    = out_valid_c & live;
    assign busy_refresh = busy_c & live;
    assign holder_fetch = fetch_c & live;

    for (genvar gi = 0; gi < d; gi++) begin : g_share
        assign holder_enable[gi] = enable_c & live;
        assign holder_shares[gi*RFRSH_RATE +: RFRSH_RATE] =
            live ? in_data[gi*RFRSH_RATE +: RFRSH_RATE] : '0;
    end

    for (genvar gi = 0; gi < d - 1; gi++) begin : g_rnd
        assign holder_rnd[gi*RFRSH_RATE +: RFRSH_RATE] =
            live ? rnd_in[gi*RFRSH_RATE +: RFRSH_RATE] : '0;
    end

endmodule

// File: tb/tb_mskdata_holder_feeder.sv
// Scoreboard bench for mskdata_holder_feeder with a behavioural model of the
// downstream holder shift register (shift-in on fetch, refresh rotation otherwise).
module tb_mskdata_holder_feeder;

    localparam int D  = 2;
    localparam int R  = 16;
    localparam int NS = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [D*R-1:0]    in_data;
    logic              rnd_valid;
    logic              rnd_ready;
    logic [R-1:0]      rnd_in;
    logic              refresh_req;
    logic              out_valid;
    logic              out_ready;
    logic              busy_refresh;
    logic [D*R-1:0]    holder_shares;
    logic [R-1:0]      holder_rnd;
    logic [D-1:0]      holder_enable;
    logic              holder_fetch;

    int checks   = 0;
    int failures = 0;

    logic [15:0] h0 [NS];
    logic [15:0] h1 [NS];
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    mskdata_holder_feeder #(.d(D), .BITS(256), .RFRSH_RATE(R)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .rnd_valid    (rnd_valid),
        .rnd_ready    (rnd_ready),
        .rnd_in       (rnd_in),
        .refresh_req  (refresh_req),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy_refresh (busy_refresh),
        .holder_shares(holder_shares),
        .holder_rnd   (holder_rnd),
        .holder_enable(holder_enable),
        .holder_fetch (holder_fetch)
    );

    // Holder model: new words enter at the top stage and move toward stage 0;
    // a refresh step moves stage 0 to the top after re-masking both shares.
    always @(posedge clk) begin
        if (holder_enable[0]) begin
            for (int i = 0; i < NS - 1; i++) h0[i] <= h0[i+1];
            h0[NS-1] <= holder_fetch ? holder_shares[15:0] : (h0[0] ^ holder_rnd);
        end
        if (holder_enable[1]) begin
            for (int i = 0; i < NS - 1; i++) h1[i] <= h1[i+1];
            h1[NS-1] <= holder_fetch ? holder_shares[31:16] : (h1[0] ^ holder_rnd);
        end
    end

    task automatic test_reset();
        logic [54:0] outs;
        rst = 1'b1; in_valid = 1'b1; in_data = $urandom; rnd_valid = 1'b1;
        rnd_in = 16'h1234; refresh_req = 1'b1; out_ready = 1'b1;
        @(negedge clk); #1;
        outs = {in_ready, rnd_ready, out_valid, busy_refresh, holder_shares,
                holder_rnd, holder_enable, holder_fetch};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_outputs_zero got=%h exp=0", outs);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0; refresh_req = 1'b0; out_ready = 1'b0;
        #1;
        checks++;
        if ({in_ready, holder_fetch, out_valid, busy_refresh, rnd_ready, holder_enable} !== 7'b1100000) begin
            failures++;
            $display("FAIL reset_release_state got=%b exp=1100000",
                     {in_ready, holder_fetch, out_valid, busy_refresh, rnd_ready, holder_enable});
        end
        $display("reset: released, checks=%0d", checks);
    endtask

    task automatic test_fill();
        logic [31:0] w, e;
        for (int k = 0; k < NS; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            w = {16'hA5A5 ^ 16'(k), 16'(k)};
            in_data = w;
            #1;
            checks++;
            if ({in_ready, holder_enable, holder_fetch, out_valid} !== 5'b11110) begin
                failures++;
                $display("FAIL fill_ctrl k=%0d got=%b exp=11110", k,
                         {in_ready, holder_enable, holder_fetch, out_valid});
            end
            checks++;
            if (holder_shares !== w) begin
                failures++;
                $display("FAIL fill_passthru k=%0d got=%h exp=%h", k, holder_shares, w);
            end
            sb.push_back(w);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            failures++;
            $display("FAIL fill_out_valid got=%b exp=10", {out_valid, in_ready});
        end
        for (int k = 0; k < NS; k++) begin
            e = sb.pop_front();
            $display("fill word %0d holder=%h exp=%h", k, {h1[k], h0[k]}, e);
            checks++;
            if ({h1[k], h0[k]} !== e || (h1[k] ^ h0[k]) !== 16'hA5A5) begin
                failures++;
                $display("FAIL fill_holder k=%0d got=%h exp=%h", k, {h1[k], h0[k]}, e);
            end
        end
    endtask

    task automatic test_backpressure();
        int hs;
        logic [31:0] e;
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_consume got=%b exp=1", out_valid);
        end
        hs = 0;
        for (int c = 0; c < 2 * NS; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = (c % 2 == 0);
            in_data = $urandom;
            #1;
            checks++;
            if (holder_enable !== {2{in_valid}} || out_valid !== (hs == NS)) begin
                failures++;
                $display("FAIL bp_cycle c=%0d got=en%b ov%b exp=en%b ov%b", c,
                         holder_enable, out_valid, {2{in_valid}}, (hs == NS));
            end
            if (in_valid && hs < NS) begin
                sb.push_back(in_data);
                hs++;
            end
        end
        in_valid = 1'b0;
        for (int k = 0; k < NS; k++) begin
            e = sb.pop_front();
            $display("bp word %0d holder=%h exp=%h", k, {h1[k], h0[k]}, e);
            checks++;
            if ({h1[k], h0[k]} !== e) begin
                failures++;
                $display("FAIL bp_holder k=%0d got=%h exp=%h", k, {h1[k], h0[k]}, e);
            end
        end
    endtask

    task automatic test_refresh(input int gap_start, input int gap_len);
        logic [15:0] s0 [NS];
        int busy_cycles, nhs;
        bit done;
        logic [31:0] e;
        for (int k = 0; k < NS; k++) begin
            s0[k] = h0[k];
            sb.push_back({16'h0, h0[k] ^ h1[k]});
        end
        @(negedge clk);
        refresh_req = 1'b1;
        #1;
        checks++;
        if ({busy_refresh, out_valid} !== 2'b01) begin
            failures++;
            $display("FAIL refresh_request got=%b exp=01", {busy_refresh, out_valid});
        end
        busy_cycles = 0; nhs = 0; done = 1'b0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            refresh_req = 1'b0;
            rnd_valid = !(gap_len > 0 && nhs == gap_start && busy_cycles < gap_start + gap_len);
            rnd_in = 16'($urandom) | 16'h1;
            #1;
            if (busy_refresh) begin
                busy_cycles++;
                checks++;
                if (holder_enable !== {2{rnd_valid}} || {rnd_ready, out_valid, holder_fetch, in_ready} !== 4'b1000
                    || holder_rnd !== rnd_in) begin
                    failures++;
                    $display("FAIL refresh_cycle c=%0d got=en%b ctl%b rnd%h exp=en%b ctl1000 rnd%h", cyc,
                             holder_enable, {rnd_ready, out_valid, holder_fetch, in_ready}, holder_rnd,
                             {2{rnd_valid}}, rnd_in);
                end
                if (rnd_valid) nhs++;
            end else begin
                done = 1'b1;
                checks++;
                if ({out_valid, rnd_ready} !== 2'b10) begin
                    failures++;
                    $display("FAIL refresh_return got=%b exp=10", {out_valid, rnd_ready});
                end
            end
        end
        rnd_valid = 1'b0;
        checks++;
        if (!done || busy_cycles != NS + gap_len) begin
            failures++;
            $display("FAIL refresh_duration got=%0d exp=%0d", busy_cycles, NS + gap_len);
        end
        for (int k = 0; k < NS; k++) begin
            e = sb.pop_front();
            $display("refresh word %0d unmasked=%h exp=%h share0 %h->%h", k,
                     h0[k] ^ h1[k], e[15:0], s0[k], h0[k]);
            checks++;
            if ((h0[k] ^ h1[k]) !== e[15:0] || h0[k] === s0[k]) begin
                failures++;
                $display("FAIL refresh_word k=%0d got=%h/%h exp=%h/not_%h", k,
                         h0[k] ^ h1[k], h0[k], e[15:0], s0[k]);
            end
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        out_ready = 1'b1; refresh_req = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL collision_full got=%b exp=1", out_valid);
        end
        @(negedge clk);
        out_ready = 1'b0; refresh_req = 1'b0;
        #1;
        checks++;
        if ({busy_refresh, in_ready, out_valid, rnd_ready} !== 4'b0100) begin
            failures++;
            $display("FAIL collision_next got=%b exp=0100", {busy_refresh, in_ready, out_valid, rnd_ready});
        end
        $display("collision: consumption taken, refresh dropped");
    endtask

    task automatic test_reset_mid_load();
        logic [54:0] outs;
        logic [31:0] e;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = $urandom;
        end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; rnd_valid = 1'b1; in_data = 32'hDEADBEEF; rnd_in = 16'hBEEF;
        #1;
        outs = {in_ready, rnd_ready, out_valid, busy_refresh, holder_shares,
                holder_rnd, holder_enable, holder_fetch};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h exp=0", outs);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL midreset_release got=%b exp=10", {in_ready, out_valid});
        end
        sb.delete();
        for (int k = 0; k < NS; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = $urandom;
            #1;
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                failures++;
                $display("FAIL midreset_load k=%0d got=%b exp=01", k, {out_valid, in_ready});
            end
            sb.push_back(in_data);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL midreset_full got=%b exp=1", out_valid);
        end
        for (int k = 0; k < NS; k++) begin
            e = sb.pop_front();
            $display("reload word %0d holder=%h exp=%h", k, {h1[k], h0[k]}, e);
            checks++;
            if ({h1[k], h0[k]} !== e) begin
                failures++;
                $display("FAIL midreset_holder k=%0d got=%h exp=%h", k, {h1[k], h0[k]}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_backpressure();
        test_refresh(0, 0);
        test_refresh(8, 5);
        test_collision();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
